// File: rtl/encode42_seq_if.sv
// Request/handshake bundle for the registered 4-to-2 priority encoder.
// The slave modport is the encoder side; master is the requester/consumer side.
interface encode42_seq_if;
   logic       en;
   logic [3:0] req;
   logic       ready;
   logic [1:0] code;
   logic       valid;
   logic [3:0] pend;
   logic       busy;

   modport master (output en, req, ready, input code, valid, pend, busy);
   modport slave  (input en, req, ready, output code, valid, pend, busy);
endinterface

// File: rtl/encode42_seq.sv
// Registered 4-to-2 priority encoder: captures request lines into a pending
// register and presents the highest pending index over a valid/ready handshake.
module encode42_seq (
   input  logic                clk,
   input  logic                rst_n,
   encode42_seq_if.slave       bus
);
   localparam int unsigned NREQ = 4;
   localparam int unsigned CW   = 2;

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t            state, state_nx;
   logic [NREQ-1:0]   pend, pend_nx, cap, rem;
   logic [CW-1:0]     code, code_nx;
   logic              valid, valid_nx;
   logic              busy, busy_nx;

   // Highest set bit wins; an all-zero vector maps to 0 but is never loaded.
   function automatic logic [CW-1:0] prio(input logic [NREQ-1:0] v);
      if (v[3])      return CW'(3);
      else if (v[2]) return CW'(2);
      else if (v[1]) return CW'(1);
      else           return CW'(0);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= '0;
         code  <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_nx;
         pend  <= pend_nx;
         code  <= code_nx;
         valid <= valid_nx;
         busy  <= busy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      code_nx  = code;
      valid_nx = valid;
      rem      = '0;
      cap      = bus.en ? bus.req : '0;
      pend_nx  = pend | cap;
      case (state)
         IDLE: begin
            valid_nx = 1'b0;
            if (pend != '0) begin
               code_nx  = prio(pend);
               valid_nx = 1'b1;
               state_nx = PRESENT;
            end
         end
         PRESENT: begin
            if (bus.ready) begin
               // Clear the accepted bit before merging new requests so set wins.
               rem     = (pend & ~(NREQ'(1) << code)) | cap;
               pend_nx = rem;
               if (rem != '0) begin
                  code_nx = prio(rem);
               end else begin
                  valid_nx = 1'b0;
                  state_nx = IDLE;
               end
            end
         end
         default: begin
            state_nx = IDLE;
            valid_nx = 1'b0;
         end
      endcase
      busy_nx = (pend_nx != '0) | valid_nx;
   end

   assign bus.code  = code;
   assign bus.valid = valid;
   assign bus.pend  = pend;
   assign bus.busy  = busy;
endmodule

// File: tb/tb_encode42_seq.sv
// Bench for encode42_seq: constant vector table, directed corner sequences
// and random traffic compared against a set-based reference model.
module tb_encode42_seq;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   encode42_seq_if bus ();
   encode42_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       rst_n;
      bit       en;
      bit [3:0] req;
      bit       ready;
      bit [1:0] code;
      bit       valid;
      bit [3:0] pend;
      bit       busy;
   } vec_t;

   // Reference model: pending set, presented index, valid flag.
   bit [3:0] m_pend;
   bit [1:0] m_code;
   bit       m_valid;

   function automatic int top_bit(bit [3:0] v);
      for (int i = 3; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_step(input bit r, input bit e, input bit [3:0] rq, input bit rd);
      bit [3:0] newreq;
      bit [3:0] left;
      newreq = e ? rq : 4'b0;
      if (!r) begin
         m_pend = 0; m_code = 0; m_valid = 0;
      end else if (!m_valid) begin
         if (m_pend != 0) begin
            m_code  = 2'(top_bit(m_pend));
            m_valid = 1;
         end
         m_pend = m_pend | newreq;
      end else if (rd) begin
         left = m_pend;
         left[m_code] = 1'b0;
         left = left | newreq;
         m_pend = left;
         if (left != 0) m_code = 2'(top_bit(left));
         else           m_valid = 0;
      end else begin
         m_pend = m_pend | newreq;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, advance the model, compare DUT to model.
   task automatic drive(input bit r, input bit e, input bit [3:0] rq, input bit rd);
      rst_n = r; bus.en = e; bus.req = rq; bus.ready = rd;
      @(posedge clk);
      model_step(r, e, rq, rd);
      #1;
      chk("model.valid", int'(bus.valid), int'(m_valid));
      chk("model.pend",  int'(bus.pend),  int'(m_pend));
      chk("model.busy",  int'(bus.busy),  int'((m_pend != 0) || m_valid));
      chk("model.code",  int'(bus.code),  int'(m_code));
   endtask

   task automatic expect_out(input string name, input bit [1:0] c, input bit v,
                             input bit [3:0] p, input bit b);
      chk({name, ".code"},  int'(bus.code),  int'(c));
      chk({name, ".valid"}, int'(bus.valid), int'(v));
      chk({name, ".pend"},  int'(bus.pend),  int'(p));
      chk({name, ".busy"},  int'(bus.busy),  int'(b));
   endtask

   vec_t tbl[15];

   initial begin
      rst_n = 1'b0; bus.en = 1'b0; bus.req = 4'b0; bus.ready = 1'b0;
      m_pend = 0; m_code = 0; m_valid = 0;

      // reset, single request held then accepted, priority drain 3,1,0
      tbl[0]  = '{0,1,4'hF,0, 0,0,4'b0000,0};
      tbl[1]  = '{0,1,4'hF,0, 0,0,4'b0000,0};
      tbl[2]  = '{1,1,4'b0100,0, 0,0,4'b0100,1};
      tbl[3]  = '{1,0,4'b0000,0, 2,1,4'b0100,1};
      tbl[4]  = '{1,0,4'b0000,0, 2,1,4'b0100,1};
      tbl[5]  = '{1,0,4'b0000,0, 2,1,4'b0100,1};
      tbl[6]  = '{1,0,4'b0000,0, 2,1,4'b0100,1};
      tbl[7]  = '{1,0,4'b0000,0, 2,1,4'b0100,1};
      tbl[8]  = '{1,0,4'b0000,1, 2,0,4'b0000,0};
      tbl[9]  = '{1,1,4'b1011,0, 2,0,4'b1011,1};
      tbl[10] = '{1,0,4'b0000,1, 3,1,4'b1011,1};
      tbl[11] = '{1,0,4'b0000,1, 1,1,4'b0011,1};
      tbl[12] = '{1,0,4'b0000,1, 0,1,4'b0001,1};
      tbl[13] = '{1,0,4'b0000,1, 0,0,4'b0000,0};
      tbl[14] = '{1,0,4'b0000,0, 0,0,4'b0000,0};

      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].rst_n, tbl[i].en, tbl[i].req, tbl[i].ready);
         expect_out($sformatf("vec%0d", i), tbl[i].code, tbl[i].valid, tbl[i].pend, tbl[i].busy);
      end

      // late higher-priority request does not displace the presented code
      drive(1, 1, 4'b0010, 0); expect_out("late.cap",  0, 0, 4'b0010, 1);
      drive(1, 0, 4'b0000, 0); expect_out("late.pres", 1, 1, 4'b0010, 1);
      drive(1, 1, 4'b1000, 0); expect_out("late.hold", 1, 1, 4'b1010, 1);
      drive(1, 0, 4'b0000, 0); expect_out("late.hold2",1, 1, 4'b1010, 1);
      drive(1, 0, 4'b0000, 1); expect_out("late.next", 3, 1, 4'b1000, 1);
      drive(1, 0, 4'b0000, 1); expect_out("late.done", 3, 0, 4'b0000, 0);

      // set wins over clear while req[2] held
      drive(1, 1, 4'b0100, 1); expect_out("setw.cap", 3, 0, 4'b0100, 1);
      drive(1, 1, 4'b0100, 1); expect_out("setw.p0",  2, 1, 4'b0100, 1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 4'b0100, 1);
         expect_out($sformatf("setw.p%0d", i + 1), 2, 1, 4'b0100, 1);
      end
      drive(1, 1, 4'b0000, 1); expect_out("setw.end", 2, 0, 4'b0000, 0);

      // reset mid-handshake discards everything
      drive(1, 1, 4'b0111, 0); expect_out("rmid.cap",  2, 0, 4'b0111, 1);
      drive(1, 0, 4'b0000, 0); expect_out("rmid.pres", 2, 1, 4'b0111, 1);
      drive(0, 0, 4'b0000, 1); expect_out("rmid.rst",  0, 0, 4'b0000, 0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 4'b0000, 1);
         expect_out($sformatf("rmid.q%0d", i), 0, 0, 4'b0000, 0);
      end

      // randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         bit       r;
         bit       e;
         bit [3:0] rq;
         bit       rd;
         r  = ($urandom_range(0, 99) != 0);
         e  = ($urandom_range(0, 3) != 0);
         rq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
         rd = ($urandom_range(0, 2) != 0);
         drive(r, e, rq, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/encode42_seq.md
# encode42_seq

Registered 4-to-2 priority encoder with request capture and a valid/ready output handshake. It is the encode-side counterpart to the 2-to-4 one-hot decoder: the encoder turns request lines into a 2-bit index, and the decoder turns that index back into a line select. Four request lines are sampled into a pending register. The highest-index pending line is encoded onto `code` and held until the consumer accepts it. Each accepted request clears its pending bit, so every captured request is presented exactly once.

## Interface
- No parameters. Width is fixed at 4 request lines and a 2-bit code.
- clk    input   1  rising-edge clock; the only clock.
- rst_n  input   1  synchronous, active-low reset.
- en     input   1  capture enable. When low, `req` is ignored and existing pending requests still drain.
- req    input   4  request lines, level-sampled each cycle while `en`=1.
- ready  input   1  consumer accepts `code` when `valid`=1 and `ready`=1 at a clock edge.
- code   output  2  index of the presented request; 3 is the highest priority.
- valid  output  1  `code` is meaningful.
- pend   output  4  current pending register, registered.
- busy   output  1  `pend`≠0 or `valid`=1, registered.

## Operation
- Capture: at each edge with `en`=1, `pend` is updated to `pend` | `req`. A request held high re-sets its bit on every cycle, so level requests keep re-requesting.
- Priority: the highest set bit of `pend` wins (3 > 2 > 1 > 0). The selected value is 3 for bit 3, 2 for bit 2, 1 for bit 1 and 0 for bit 0.
- State machine has two states: IDLE and PRESENT.
  - IDLE: `valid`=0. If `pend`≠0, at the edge load `code` = priority(`pend`), set `valid`=1 and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: `valid`=1 and `code` is held stable while `ready`=0.
  - PRESENT with `ready`=1 at an edge, on the accepted bit `b`=`code`:
    - Clear `pend[b]`.
    - Compute remaining = (`pend` with bit `b` cleared) | (`req` if `en`=1).
    - If remaining≠0, load `code` = priority(remaining) and stay in PRESENT with `valid`=1. This gives back-to-back presentation with no bubble.
    - If remaining=0, drop `valid` to 0 and go to IDLE.
- Simultaneous clear and set of the same bit (accept of `b` while `req[b]`=1 and `en`=1): set wins. `pend[b]` stays 1 and `b` is presented again.
- A higher-priority request arriving while a lower code is presented does not change `code`. It is taken at the next load.
- `code` when `valid`=0 keeps its last loaded value and carries no meaning.

## Timing
- Reset, when `rst_n`=0 at an edge: `pend`=0, `code`=0, `valid`=0, `busy`=0, state=IDLE. Reset wins over every other input at that edge, including mid-handshake. Any pending or presented request is discarded and not presented later.
- Latency from IDLE: `req[i]` sampled at edge k sets `pend[i]` at edge k. `valid`=1 with `code`=i is visible after edge k+1, a 2-cycle latency.
- Throughput: one accept per cycle when `ready` is held high and requests remain pending.
- `busy` is registered from the next-state values of `pend` and `valid`, so it updates on the same edge as they do.
- `en` falling mid-transfer: the current `code` stays valid until accepted and the remaining pending bits drain. No new bits are set.
- All pending set with `en`=0 and `ready` held high: codes 3, 2, 1, 0 appear on consecutive cycles, then `valid`=0 and `busy`=0.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with `req`=4'b1111 and `en`=1 → `pend`=0, `valid`=0, `code`=0, `busy`=0.
- Single request: one-cycle pulse `req`=4'b0100 with `ready`=0 → after 2 edges `valid`=1 and `code`=2. `code` and `valid` are held 5 cycles. Raise `ready` for 1 cycle → `valid`=0 and `pend`=0 on the next cycle.
- Priority drain: one-cycle pulse `req`=4'b1011, then `en`=0 and `ready`=1 → `code` sequence 3, 1, 0 on consecutive cycles, then `valid`=0.
- Late higher-priority request: `code`=1 presented with `ready`=0, then a pulse on `req[3]` → `code` stays 1. After accept, `code`=3 on the next cycle.
- Set-wins: hold `req[2]`=1, `en`=1 and `ready`=1 → `code`=2 is presented every cycle and `pend[2]` stays 1. Drop `req[2]` → one further presentation of `code`=2, then `valid`=0.
- Reset mid-operation: `pend`=4'b0111 with `valid`=1 and `code`=2, then `rst_n`=0 for 1 cycle → all outputs 0. With `req`=0 afterwards, `valid` never reasserts.
